// File: rtl/mul_rr_arbiter_pkg.sv
// Shared types and widths for the multiplier arbiter.
// Used by the interface, the picker, the multiplier and the top.
package mul_arb_pkg;

  localparam int unsigned OPERAND_W = 32;
  localparam int unsigned PRODUCT_W = 64;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StHold = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mul_rr_arbiter_if.sv
// Request/response bundle for mul_rr_arbiter.
// slave: the arbiter side. master: the requesters plus the response consumer.
interface mul_rr_arbiter_if
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = $clog2(NUM_REQ)
) ();

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ-1:0]           req_ready;
  logic [NUM_REQ*OPERAND_W-1:0] req_a;
  logic [NUM_REQ*OPERAND_W-1:0] req_b;
  logic                         rsp_valid;
  logic                         rsp_ready;
  logic [PRODUCT_W-1:0]         rsp_product;
  logic [ID_W-1:0]              rsp_id;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_product, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_product, rsp_id
  );

endinterface

// File: rtl/mul_rr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i,
// wrapping around. idx_o is zero when no request is set.
module rr_picker #(
  parameter int unsigned NumReq = 4,
  parameter int unsigned IdW    = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] req_i,
  input  logic [IdW-1:0]    ptr_i,
  output logic              any_o,
  output logic [IdW-1:0]    idx_o
);

  // Scan NumReq positions starting at the pointer; keep the first hit.
  always_comb begin
    logic           found;
    logic [IdW-1:0] idx;
    int unsigned    j;
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j = (32'(ptr_i) + k) % NumReq;
      if (!found && req_i[IdW'(j)]) begin
        found = 1'b1;
        idx   = IdW'(j);
      end
    end
    any_o = found;
    idx_o = idx;
  end

endmodule

// File: rtl/mul_rr_arbiter_wallace.sv
// 32x32 unsigned Wallace-tree multiplier, purely combinational.
// Partial-product rows are reduced with word-wide 3:2 carry-save layers
// (32->22->15->10->7->5->4->3->2) and a final carry-propagate add.
module wallace_mul32
  import mul_arb_pkg::*;
(
  input  logic [OPERAND_W-1:0] a_i,
  input  logic [OPERAND_W-1:0] b_i,
  output logic [PRODUCT_W-1:0] p_o
);

  localparam int unsigned Rows   = OPERAND_W;
  localparam int unsigned IdxW   = $clog2(Rows);
  localparam int unsigned Stages = 8;

  // Build partial products, compress layer by layer, then add the last two rows.
  always_comb begin
    logic [PRODUCT_W-1:0] rows [Rows];
    logic [PRODUCT_W-1:0] nxt  [Rows];
    logic [PRODUCT_W-1:0] x, y, z, maj;
    int unsigned          cnt, n, groups;

    for (int unsigned i = 0; i < Rows; i++) begin
      rows[i] = b_i[i] ? (PRODUCT_W'(a_i) << i) : '0;
      nxt[i]  = '0;
    end
    cnt    = Rows;
    n      = 0;
    groups = 0;
    x      = '0;
    y      = '0;
    z      = '0;
    maj    = '0;

    for (int unsigned s = 0; s < Stages; s++) begin
      n      = 0;
      groups = cnt / 3;
      for (int unsigned i = 0; i < Rows; i++) begin
        nxt[i] = '0;
      end
      // Each full triple of rows becomes a sum row and a shifted carry row.
      for (int unsigned g = 0; g < Rows / 3; g++) begin
        x   = rows[IdxW'(3 * g)];
        y   = rows[IdxW'(3 * g + 1)];
        z   = rows[IdxW'(3 * g + 2)];
        maj = (x & y) | (x & z) | (y & z);
        if (g < groups) begin
          nxt[IdxW'(n)]     = x ^ y ^ z;
          nxt[IdxW'(n + 1)] = {maj[PRODUCT_W-2:0], 1'b0};
          n                 = n + 2;
        end
      end
      // Rows left over after the last full triple pass straight through.
      for (int unsigned r = 0; r < Rows; r++) begin
        if (r >= 3 * groups && r < cnt) begin
          nxt[IdxW'(n)] = rows[r];
          n             = n + 1;
        end
      end
      rows = nxt;
      cnt  = n;
    end

    p_o = rows[0] + rows[1];
  end

endmodule

// File: rtl/mul_rr_arbiter.sv
// Round-robin arbiter sharing one Wallace-tree multiplier among NUM_REQ
// requesters. Grant -> operand registers -> product register -> held response.
// Optional build macro MUL_RR_ARBITER_STATS_EN adds a 32-bit handshake counter
// on port op_count.
module mul_rr_arbiter
  import mul_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  mul_rr_arbiter_if.slave bus
`ifdef MUL_RR_ARBITER_STATS_EN
  ,
  output logic [31:0]     op_count
`endif
);

  arb_state_e           state_q, state_d;
  logic [ID_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]      id_q, id_d;
  logic [ID_W-1:0]      rsp_id_q, rsp_id_d;
  logic [OPERAND_W-1:0] op_a_q, op_a_d;
  logic [OPERAND_W-1:0] op_b_q, op_b_d;
  logic [PRODUCT_W-1:0] rsp_product_q, rsp_product_d;
  logic [PRODUCT_W-1:0] mul_p;
  logic [NUM_REQ-1:0]   req_ready_d;
  logic                 any_req;
  logic                 grant_en;
  logic [ID_W-1:0]      pick_idx;

  logic [OPERAND_W-1:0] req_a_arr [NUM_REQ];
  logic [OPERAND_W-1:0] req_b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign req_a_arr[i] = bus.req_a[OPERAND_W*i +: OPERAND_W];
    assign req_b_arr[i] = bus.req_b[OPERAND_W*i +: OPERAND_W];
  end

  rr_picker #(
    .NumReq (NUM_REQ),
    .IdW    (ID_W)
  ) u_picker (
    .req_i (bus.req_valid),
    .ptr_i (rr_ptr_q),
    .any_o (any_req),
    .idx_o (pick_idx)
  );

  wallace_mul32 u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (mul_p)
  );

  // Next state and grant decision; a grant is possible from IDLE, or from HOLD
  // in the same cycle the response is accepted.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          grant_en = 1'b1;
          state_d  = StMul;
        end
      end
      StMul: begin
        state_d = StHold;
      end
      StHold: begin
        if (bus.rsp_ready) begin
          if (any_req) begin
            grant_en = 1'b1;
            state_d  = StMul;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Datapath next values: latch the granted operands, capture the product in MUL.
  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    op_a_d        = op_a_q;
    op_b_d        = op_b_q;
    id_d          = id_q;
    rsp_product_d = rsp_product_q;
    rsp_id_d      = rsp_id_q;
    req_ready_d   = '0;
    if (grant_en) begin
      req_ready_d[pick_idx] = 1'b1;
      op_a_d                = req_a_arr[pick_idx];
      op_b_d                = req_b_arr[pick_idx];
      id_d                  = pick_idx;
      // Just-served requester drops to lowest priority.
      rr_ptr_d              = (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
    if (state_q == StMul) begin
      rsp_product_d = mul_p;
      rsp_id_d      = id_q;
    end
  end

  // State and datapath registers; reset discards any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      rr_ptr_q      <= '0;
      op_a_q        <= '0;
      op_b_q        <= '0;
      id_q          <= '0;
      rsp_product_q <= '0;
      rsp_id_q      <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      op_a_q        <= op_a_d;
      op_b_q        <= op_b_d;
      id_q          <= id_d;
      rsp_product_q <= rsp_product_d;
      rsp_id_q      <= rsp_id_d;
    end
  end

  assign bus.req_ready   = req_ready_d;
  assign bus.rsp_valid   = (state_q == StHold);
  assign bus.rsp_product = rsp_product_q;
  assign bus.rsp_id      = rsp_id_q;

`ifdef MUL_RR_ARBITER_STATS_EN
  logic [31:0] op_count_q, op_count_d;
  logic        handshake;

  assign handshake = (state_q == StHold) && bus.rsp_ready;

  // Count accepted responses; wraps naturally at 2^32.
  always_comb begin
    op_count_d = op_count_q;
    if (handshake) begin
      op_count_d = op_count_q + 32'd1;
    end
  end

  // Handshake counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_q <= '0;
    end else begin
      op_count_q <= op_count_d;
    end
  end

  assign op_count = op_count_q;
`endif

endmodule

// File: tb/tb_mul_rr_arbiter.sv
// Self-checking bench for mul_rr_arbiter: table of single requests, hand-written
// rotation/backpressure/reset sequences, random traffic, and a scoreboard of
// expected responses pushed at grant time and popped at each handshake.
module tb_mul_rr_arbiter;
  import mul_arb_pkg::*;

  localparam int unsigned N   = 4;
  localparam int unsigned IdW = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  mul_rr_arbiter_if #(.NUM_REQ(N)) bus ();

`ifdef MUL_RR_ARBITER_STATS_EN
  logic [31:0] op_count;
`endif

  mul_rr_arbiter #(.NUM_REQ(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MUL_RR_ARBITER_STATS_EN
    ,
    .op_count (op_count)
`endif
  );

  typedef struct {
    int unsigned idx;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  rdy;
    logic [63:0] prod;
  } vec_t;

  typedef struct {
    logic [63:0] prod;
    int unsigned id;
  } exp_t;

  typedef enum {MIdle, MMul, MHold} mstate_e;

  exp_t        sbq[$];
  int unsigned id_log[$];
  int unsigned cyc_log[$];
  int unsigned checks = 0;
  int unsigned passed = 0;
  int unsigned cyc    = 0;
  mstate_e     mst    = MIdle;
  int unsigned mptr   = 0;
  logic [63:0] cur_exp [N];
  logic        stall_prev = 1'b0;
  logic [63:0] prev_prod  = '0;
  logic [63:0] prev_id    = '0;
  logic [31:0] hs_count   = '0;
  vec_t        vecs [7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int unsigned model_pick(input logic [N-1:0] v, input int unsigned ptr);
    for (int unsigned k = 0; k < N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return 0;
  endfunction

  task automatic set_req(input int unsigned i, input logic [31:0] a, input logic [31:0] b);
    bus.req_a[32*i +: 32] = a;
    bus.req_b[32*i +: 32] = b;
    cur_exp[i] = {32'b0, a} * {32'b0, b};
  endtask

  // Per-cycle checks just before the rising edge, then advance the model.
  task automatic mon();
    logic [N-1:0] exp_rdy;
    logic         grant;
    int unsigned  g;
    exp_t         e;
    cyc++;
    exp_rdy = '0;
    grant   = 1'b0;
    g       = 0;
    if ((mst == MIdle || (mst == MHold && bus.rsp_ready)) && |bus.req_valid) begin
      grant      = 1'b1;
      g          = model_pick(bus.req_valid, mptr);
      exp_rdy[g] = 1'b1;
    end
    chk("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    chk("rsp_valid", 64'(bus.rsp_valid), 64'(mst == MHold));
    if (stall_prev) begin
      chk("hold_product", bus.rsp_product, prev_prod);
      chk("hold_id", 64'(bus.rsp_id), prev_id);
    end
    stall_prev = bus.rsp_valid && !bus.rsp_ready;
    prev_prod  = bus.rsp_product;
    prev_id    = 64'(bus.rsp_id);
`ifdef MUL_RR_ARBITER_STATS_EN
    chk("op_count", 64'(op_count), 64'(hs_count));
`endif
    if (bus.rsp_valid && bus.rsp_ready) begin
      chk("sb_nonempty", 64'(sbq.size() != 0), 64'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("rsp_product", bus.rsp_product, e.prod);
        chk("rsp_id", 64'(bus.rsp_id), 64'(e.id));
      end
      id_log.push_back(32'(bus.rsp_id));
      cyc_log.push_back(cyc);
      hs_count = hs_count + 32'd1;
    end
    if (grant) begin
      sbq.push_back('{cur_exp[g], g});
      mptr = (g + 1) % N;
    end
    case (mst)
      MIdle: if (grant) mst = MMul;
      MMul:  mst = MHold;
      MHold: if (bus.rsp_ready) mst = grant ? MMul : MIdle;
      default: mst = MIdle;
    endcase
  endtask

  // Called at a falling edge.
  task automatic step();
    #4;
    mon();
    @(negedge clk);
  endtask

  // Called 1 time unit after a falling edge.
  task automatic step_rest();
    #3;
    mon();
    @(negedge clk);
  endtask

  task automatic do_reset(input int unsigned cycles_low);
    bus.req_valid = '0;
    rst_n         = 1'b0;
    #1;
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_product", bus.rsp_product, 64'd0);
    chk("rst_rsp_id", 64'(bus.rsp_id), 64'd0);
    chk("rst_req_ready", 64'(bus.req_ready), 64'd0);
    sbq.delete();
    mst        = MIdle;
    mptr       = 0;
    stall_prev = 1'b0;
    hs_count   = '0;
    repeat (cycles_low) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < N; i++) cur_exp[i] = '0;

    vecs[0] = '{2, 32'd7, 32'd6, 4'b0100, 64'd42};
    vecs[1] = '{2, 32'd65535, 32'd65537, 4'b0100, 64'h0000_0000_FFFF_FFFF};
    vecs[2] = '{0, 32'hFFFF_FFFF, 32'd2, 4'b0001, 64'h0000_0001_FFFF_FFFE};
    vecs[3] = '{3, 32'h8000_0000, 32'h8000_0000, 4'b1000, 64'h4000_0000_0000_0000};
    vecs[4] = '{1, 32'd12345, 32'd6789, 4'b0010, 64'd83810205};
    vecs[5] = '{1, 32'hDEAD_BEEF, 32'd0, 4'b0010, 64'd0};
    vecs[6] = '{3, 32'hFFFF_FFFF, 32'd1, 4'b1000, 64'h0000_0000_FFFF_FFFF};

    @(negedge clk);
    do_reset(2);
    repeat (2) step();

    // Single requests, one at a time.
    for (int v = 0; v < 7; v++) begin
      set_req(vecs[v].idx, vecs[v].a, vecs[v].b);
      bus.req_valid = 4'b0001 << vecs[v].idx;
      bus.rsp_ready = 1'b1;
      #1;
      chk("tbl_grant", 64'(bus.req_ready), 64'(vecs[v].rdy));
      step_rest();
      bus.req_valid = '0;
      step();
      chk("tbl_valid", 64'(bus.rsp_valid), 64'd1);
      chk("tbl_product", bus.rsp_product, vecs[v].prod);
      chk("tbl_id", 64'(bus.rsp_id), 64'(vecs[v].idx));
      step();
      step();
    end

    // Rotation with all requesters continuously valid.
    for (int i = 0; i < N; i++) set_req(i, 32'(1000 + i * 17), 32'(3 + i));
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    id_log.delete();
    cyc_log.delete();
    repeat (11) step();
    chk("rot_count", 64'(id_log.size()), 64'd5);
    for (int k = 0; k < 5 && k < id_log.size(); k++) begin
      chk("rot_id", 64'(id_log[k]), 64'(k % 4));
      if (k > 0) chk("rot_gap", 64'(cyc_log[k] - cyc_log[k-1]), 64'd2);
    end
    bus.req_valid = '0;
    repeat (3) step();

    // Backpressure with the largest operands; requester 3 waits meanwhile.
    set_req(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus.req_valid = 4'b0010;
    bus.rsp_ready = 1'b0;
    step();
    set_req(3, 32'd5, 32'd9);
    bus.req_valid = 4'b1000;
    step();
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("bp_product", bus.rsp_product, 64'hFFFF_FFFE_0000_0001);
      chk("bp_ready", 64'(bus.req_ready), 64'd0);
      step_rest();
    end
    bus.rsp_ready = 1'b1;
    #1;
    chk("bp_release_valid", 64'(bus.rsp_valid), 64'd1);
    chk("bp_release_grant", 64'(bus.req_ready), 64'b1000);
    step_rest();
    bus.req_valid = '0;
    repeat (3) step();

    // Reset while holding a response.
    set_req(2, 32'd11, 32'd13);
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    step();
    bus.req_valid = '0;
    step();
    step();
    do_reset(2);
    bus.req_valid = '1;
    #1;
    chk("rst_hold_first_grant", 64'(bus.req_ready), 64'b0001);
    step_rest();
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) step();

    // Reset while the multiply is in flight: no response may follow.
    set_req(1, 32'd100, 32'd200);
    bus.req_valid = 4'b0010;
    step();
    bus.req_valid = '0;
    do_reset(1);
    repeat (4) step();
    bus.req_valid = '1;
    #1;
    chk("rst_mul_first_grant", 64'(bus.req_ready), 64'b0001);
    step_rest();
    bus.req_valid = '0;
    repeat (3) step();

    // Random traffic and backpressure.
    for (int t = 0; t < 400; t++) begin
      bus.req_valid = 4'($urandom);
      for (int i = 0; i < N; i++) set_req(i, $urandom, $urandom);
      bus.rsp_ready = ($urandom_range(3) != 0);
      step();
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    repeat (4) step();
    chk("drain_empty", 64'(sbq.size()), 64'd0);

`ifdef MUL_RR_ARBITER_STATS_EN
    do_reset(1);
    for (int k = 0; k < 10; k++) begin
      set_req(0, 32'(k + 1), 32'd3);
      bus.req_valid = 4'b0001;
      step();
      bus.req_valid = '0;
      step();
      step();
    end
    chk("op_count_10", 64'(op_count), 64'd10);
    force dut.op_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.op_count_q;
    hs_count = 32'hFFFF_FFFF;
    set_req(0, 32'd2, 32'd2);
    bus.req_valid = 4'b0001;
    step_rest();
    bus.req_valid = '0;
    step();
    step();
    chk("op_count_wrap", 64'(op_count), 64'd0);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
